video_timing_gen: RTL
=====================

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameter W, default 48, meaning active pixels per line.
REQ-002 SHALL have parameter H, default 36, meaning active lines per frame.
REQ-003 SHALL have parameter VS_PRE, default 6, meaning cycles from Vsync rise to the first Hsync rise.
REQ-004 SHALL have parameter HS_PRE, default 5, meaning cycles from Hsync rise to the first DataEn.
REQ-005 SHALL have parameter HS_POST, default 7, meaning cycles from the last DataEn to Hsync fall.
REQ-006 SHALL have parameter H_BLANK, default 152, meaning Hsync-low cycles between lines.
REQ-007 SHALL have parameter VS_POST, default 6, meaning cycles from the last Hsync fall to Vsync fall.
REQ-008 SHALL have parameter V_GAP, default 80, meaning Vsync-low cycles between frames.
REQ-009 SHALL have parameter AW, default 20, meaning the read address width.
REQ-010 SHALL have clk, input, 1, the single clock; all logic on its rising edge.
REQ-011 SHALL have rst, input, 1, reset, synchronous and active-high.
REQ-012 SHALL have Start, input, 1, a level that requests frame generation.
REQ-013 SHALL have RdEn, output, 1, frame-memory read strobe.
REQ-014 SHALL have RdAddr, output, AW, pixel index l*W+h for the frame-memory read.
REQ-015 SHALL have PixelIn, input, 24, {R,G,B} returned by the synchronous RAM one cycle after RdEn.
REQ-016 SHALL have Vsync, Hsync and DataEn, each output, 1, video timing to the downstream operators.
REQ-017 SHALL have R, G and B, each output, 8, pixel data aligned with DataEn.
REQ-018 SHALL have PixelX and PixelY, each output, 12, the coordinates of the pixel on R/G/B.
REQ-019 SHALL have FrameDone, output, 1, a one-cycle pulse on the cycle Vsync falls.

Function
REQ-020 SHALL use FSM states IDLE, VS_PRE, HS_PRE, ACTIVE, HS_POST, H_BLANK, VS_POST and V_GAP, with one down/up counter per state loaded on entry.
REQ-021 SHALL go IDLE->VS_PRE when Start=1; VS_PRE->HS_PRE; HS_PRE->ACTIVE; ACTIVE->HS_POST after W cycles.
REQ-022 SHALL go HS_POST->H_BLANK if the line is below H-1, otherwise HS_POST->VS_POST; H_BLANK->HS_PRE with the line incremented.
REQ-023 SHALL go VS_POST->V_GAP, then V_GAP->VS_PRE if Start=1, else V_GAP->IDLE; Start is sampled only in IDLE and at the V_GAP exit.
REQ-024 SHALL hold each state exactly its parameter count of cycles (VS_PRE=6, HS_PRE=5, ACTIVE=W, ...).
REQ-025 SHALL assert RdEn for exactly the cycles spent in ACTIVE, with RdAddr = line*W + h, h=0..W-1.
REQ-026 SHALL hold RdAddr at its last value when RdEn=0.
REQ-027 SHALL drive Vsync, Hsync, DataEn, PixelX and PixelY through 2 register stages, so they lag the FSM by 2 cycles.
REQ-028 SHALL register R/G/B from PixelIn on the cycle after RdEn, so data, DataEn and coordinates leave on the same cycle.
REQ-029 SHALL drive Vsync=1 for the cycles spent in VS_PRE through VS_POST inclusive (delayed per REQ-027).
REQ-030 SHALL drive Hsync=1 for the cycles spent in HS_PRE, ACTIVE and HS_POST.
REQ-031 SHALL force R=G=B=0 whenever DataEn=0.
REQ-032 SHALL set the frame cycle count to VS_PRE + H*(HS_PRE+W+HS_POST) + (H-1)*H_BLANK + VS_POST, which is 7492 at the defaults.
REQ-033 SHALL set the line period to 212 cycles at the defaults.
REQ-034 SHALL generate FrameDone on the same cycle as the Vsync 1->0 output transition.
REQ-035 SHALL complete the current frame when Start falls mid-frame, then enter IDLE after V_GAP.
REQ-036 SHALL treat W=1 and H=1 as legal: a single ACTIVE cycle and no H_BLANK.

Reset
REQ-037 SHALL, on the clk edge sampling rst=1, go to IDLE, clear all counters, and flush both pipeline stages.
REQ-038 SHALL drive every output to 0 on that edge: Vsync, Hsync, DataEn, RdEn, RdAddr, R, G, B, PixelX, PixelY and FrameDone.
REQ-039 SHALL, on reset mid-frame, emit no FrameDone and leave no partial line in flight.
REQ-040 SHALL, after rst falls with Start=1, raise Vsync 3 cycles later: 1 cycle into VS_PRE plus the 2-cycle pipeline.

Verification
REQ-041 SHALL check a default frame: rst then Start=1 -> Vsync high for 7492 cycles, 36 DataEn bursts of 48 cycles, 212-cycle Hsync period, Hsync high 60 cycles per line, one FrameDone.
REQ-042 SHALL check ramp data: RAM word k={k[7:0],~k[7:0],8'h5A} -> R/G/B at PixelX=h, PixelY=l match word l*48+h; last RdAddr 1727.
REQ-043 SHALL check continuous run: Start held -> Vsync low for exactly 80 cycles between frames; Start dropped in frame 2 -> frame 2 completes, then idle.
REQ-044 SHALL check reset mid-frame: rst pulsed at line 10, pixel 20 -> all outputs 0 the next cycle, no FrameDone, the next frame starts at RdAddr 0.
REQ-045 SHALL check boundaries: W=1, H=1 -> Vsync high 6+13+6=25 cycles, one DataEn cycle, RdAddr 0.

Source files
------------

// File: rtl/video_timing_gen.sv
// Video timing generator: walks a frame as a fixed sequence of timed phases,
// reads pixels from a synchronous frame memory, and emits Vsync/Hsync/DataEn
// with aligned RGB data and pixel coordinates.
//
// Ports:
//   clk        clock, everything on the rising edge
//   rst        synchronous active-high reset
//   Start      level request to generate frames
//   RdEn       frame-memory read strobe (high for every ACTIVE cycle)
//   RdAddr     frame-memory address, line*W + pixel; holds when idle
//   PixelIn    {R,G,B} returned by the RAM one cycle after RdEn
//   Vsync      frame envelope, 2-cycle lag behind the FSM
//   Hsync      line envelope, 2-cycle lag behind the FSM
//   DataEn     active pixel qualifier, 2-cycle lag behind the FSM
//   R, G, B    pixel data aligned with DataEn, zero outside it
//   PixelX/Y   coordinates of the pixel currently on R/G/B
//   FrameDone  one-cycle pulse on the cycle Vsync falls
module video_timing_gen #(
    parameter int unsigned W       = 48,
    parameter int unsigned H       = 36,
    parameter int unsigned VS_PRE  = 6,
    parameter int unsigned HS_PRE  = 5,
    parameter int unsigned HS_POST = 7,
    parameter int unsigned H_BLANK = 152,
    parameter int unsigned VS_POST = 6,
    parameter int unsigned V_GAP   = 80,
    parameter int unsigned AW      = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          Start,
    output logic          RdEn,
    output logic [AW-1:0] RdAddr,
    input  logic [23:0]   PixelIn,
    output logic          Vsync,
    output logic          Hsync,
    output logic          DataEn,
    output logic [7:0]    R,
    output logic [7:0]    G,
    output logic [7:0]    B,
    output logic [11:0]   PixelX,
    output logic [11:0]   PixelY,
    output logic          FrameDone
);

    localparam int unsigned CW = 16;
    localparam int unsigned XW = 12;

    typedef enum logic [2:0] {
        S_IDLE,
        S_VS_PRE,
        S_HS_PRE,
        S_ACTIVE,
        S_HS_POST,
        S_H_BLANK,
        S_VS_POST,
        S_V_GAP
    } state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;      // cycles left in the current phase, minus one
    logic [XW-1:0]   px, px_nx;        // pixel index within the active line
    logic [XW-1:0]   ln, ln_nx;        // line index within the frame
    logic [AW-1:0]   addr;             // next frame-memory address to read

    logic            vs_s1, hs_s1, de_s1;
    logic [XW-1:0]   x_s1, y_s1;

    // FSM and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            px    <= '0;
            ln    <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            px    <= px_nx;
            ln    <= ln_nx;
        end
    end

    // Phase sequencing: each phase is loaded with its length minus one on entry
    always_comb begin
        state_nx = state;
        cnt_nx   = (cnt != '0) ? cnt - CW'(1) : cnt;
        px_nx    = '0;
        ln_nx    = ln;
        case (state)
            S_IDLE: begin
                if (Start) begin
                    state_nx = S_VS_PRE;
                    cnt_nx   = CW'(VS_PRE - 1);
                    ln_nx    = '0;
                end
            end
            S_VS_PRE: begin
                if (cnt == '0) begin
                    state_nx = S_HS_PRE;
                    cnt_nx   = CW'(HS_PRE - 1);
                end
            end
            S_HS_PRE: begin
                if (cnt == '0) begin
                    state_nx = S_ACTIVE;
                    cnt_nx   = CW'(W - 1);
                end
            end
            S_ACTIVE: begin
                px_nx = px + XW'(1);
                if (cnt == '0) begin
                    state_nx = S_HS_POST;
                    cnt_nx   = CW'(HS_POST - 1);
                    px_nx    = '0;
                end
            end
            S_HS_POST: begin
                if (cnt == '0) begin
                    if (ln == XW'(H - 1)) begin
                        state_nx = S_VS_POST;
                        cnt_nx   = CW'(VS_POST - 1);
                    end else begin
                        state_nx = S_H_BLANK;
                        cnt_nx   = CW'(H_BLANK - 1);
                    end
                end
            end
            S_H_BLANK: begin
                if (cnt == '0) begin
                    state_nx = S_HS_PRE;
                    cnt_nx   = CW'(HS_PRE - 1);
                    ln_nx    = ln + XW'(1);
                end
            end
            S_VS_POST: begin
                if (cnt == '0) begin
                    state_nx = S_V_GAP;
                    cnt_nx   = CW'(V_GAP - 1);
                end
            end
            S_V_GAP: begin
                if (cnt == '0) begin
                    if (Start) begin
                        state_nx = S_VS_PRE;
                        cnt_nx   = CW'(VS_PRE - 1);
                        ln_nx    = '0;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Read port and two-stage output pipeline; RdEn is built from the next
    // state so it coincides with the ACTIVE cycles and leads DataEn by two.
    always_ff @(posedge clk) begin
        if (rst) begin
            RdEn      <= 1'b0;
            RdAddr    <= '0;
            addr      <= '0;
            vs_s1     <= 1'b0;
            hs_s1     <= 1'b0;
            de_s1     <= 1'b0;
            x_s1      <= '0;
            y_s1      <= '0;
            Vsync     <= 1'b0;
            Hsync     <= 1'b0;
            DataEn    <= 1'b0;
            PixelX    <= '0;
            PixelY    <= '0;
            R         <= '0;
            G         <= '0;
            B         <= '0;
            FrameDone <= 1'b0;
        end else begin
            RdEn <= (state_nx == S_ACTIVE);
            // Lines are contiguous in memory, so a running address equals line*W + pixel
            if (state == S_IDLE || state == S_V_GAP) begin
                addr <= '0;
            end else if (state_nx == S_ACTIVE) begin
                RdAddr <= addr;
                addr   <= addr + AW'(1);
            end

            vs_s1 <= (state != S_IDLE) && (state != S_V_GAP);
            hs_s1 <= (state == S_HS_PRE) || (state == S_ACTIVE) || (state == S_HS_POST);
            de_s1 <= (state == S_ACTIVE);
            x_s1  <= (state == S_ACTIVE) ? px : '0;
            y_s1  <= (state == S_ACTIVE) ? ln : '0;

            Vsync  <= vs_s1;
            Hsync  <= hs_s1;
            DataEn <= de_s1;
            PixelX <= x_s1;
            PixelY <= y_s1;
            // RAM data for the stage-1 pixel arrives this cycle
            R <= de_s1 ? PixelIn[23:16] : '0;
            G <= de_s1 ? PixelIn[15:8]  : '0;
            B <= de_s1 ? PixelIn[7:0]   : '0;
            FrameDone <= Vsync & ~vs_s1;
        end
    end

endmodule
